// File: rtl/spi_master_param.sv
// ---------------------------------------------------------------------------
// spi_master_param
//
// Parametrised SPI master. A rising edge on SPI_STAR_I, accepted while the
// block is idle (or in its one-cycle DONE state), captures the TX word, slave
// index, SPI mode and bit count. It then runs CS setup, the SCLK shift phase
// and CS hold, and finally pulses SPI_DONE_O with the received word on SPI_O.
// A request that names a non-existent slave or an illegal length is rejected.
// A rejected request produces DONE one cycle later, with SPI_ERR_O set and no
// activity on the bus.
//
// Ports
//   BOARD_CLOCK  system clock, all logic on the rising edge
//   RST          asynchronous reset, active-high
//   SPI_STAR_I   start request (rising-edge triggered)
//   SPI_SEL_I    slave index, selects SPI_CSS[SEL]
//   SPI_MODE_I   [1]=CPOL, [0]=CPHA
//   SPI_LEN_I    number of bits to transfer, 1..DATA_W
//   SPI_I        TX word, bits [LEN-1:0] sent MSB-first
//   SPI_O        RX word, right-aligned, upper bits zero
//   SPI_DONE_O   one-cycle completion pulse
//   SPI_BUSY_O   transaction in progress
//   SPI_ERR_O    last request rejected, held until the next start
//   SPI_MISO     serial data in
//   SPI_MOSI     serial data out
//   SPI_CLK      serial clock
//   SPI_CSS      active-low chip selects
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_master_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_CS   = 3,
    parameter int SEL_W    = 2,
    parameter int LEN_W    = 6,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              BOARD_CLOCK,
    input  logic              RST,
    input  logic              SPI_STAR_I,
    input  logic [SEL_W-1:0]  SPI_SEL_I,
    input  logic [1:0]        SPI_MODE_I,
    input  logic [LEN_W-1:0]  SPI_LEN_I,
    input  logic [DATA_W-1:0] SPI_I,
    output logic [DATA_W-1:0] SPI_O,
    output logic              SPI_DONE_O,
    output logic              SPI_BUSY_O,
    output logic              SPI_ERR_O,
    input  logic              SPI_MISO,
    output logic              SPI_MOSI,
    output logic              SPI_CLK,
    output logic [NUM_CS-1:0] SPI_CSS
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t             state;
    logic               start_prev;
    logic               cpol_q;
    logic               cpha_q;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  tx_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic [DIV_W-1:0]   div_cnt;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [PH_W-1:0]    ph_cnt;

    logic               start_edge;
    logic               req_bad;
    logic [DATA_W-1:0]  tx_aligned;
    logic [NUM_CS-1:0]  cs_pattern;
    logic [EDGE_W-1:0]  last_edge;
    logic               sclk_tick;
    logic               sample_now;

    assign start_edge = SPI_STAR_I & ~start_prev;

    assign req_bad = (int'(SPI_SEL_I) >= NUM_CS) ||
                     (SPI_LEN_I == '0) ||
                     (int'(SPI_LEN_I) > DATA_W);

    // Left-align the active bits so the MSB of the transfer sits at the top
    // of the shift register and zeros follow it; unused upper bits drop out.
    assign tx_aligned = SPI_I << (DATA_W - int'(SPI_LEN_I));

    // The shift phase ends after 2*LEN SCLK toggles.
    assign last_edge = EDGE_W'(2 * int'(len_q) - 1);

    assign sclk_tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // An edge is leading when SCLK is still at its idle level before the
    // toggle. CPHA=0 samples on leading edges and CPHA=1 on trailing edges.
    assign sample_now = (SPI_CLK == cpol_q) ^ cpha_q;

    always_comb begin
        cs_pattern = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(SPI_SEL_I) == i) begin
                cs_pattern[i] = 1'b0;
            end
        end
    end

    // Single controller: sequencing, SCLK generation, shifting and all
    // registered outputs. The start detector resets to "high" so that a start
    // line held high through reset needs a fresh low-to-high edge.
    // Rejected requests leave the latched mode alone, so SCLK never moves.
    always_ff @(posedge BOARD_CLOCK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            start_prev <= 1'b1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            len_q      <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            ph_cnt     <= '0;
            SPI_O      <= '0;
            SPI_DONE_O <= 1'b0;
            SPI_BUSY_O <= 1'b0;
            SPI_ERR_O  <= 1'b0;
            SPI_MOSI   <= 1'b0;
            SPI_CLK    <= 1'b0;
            SPI_CSS    <= '1;
        end else begin
            start_prev <= SPI_STAR_I;
            SPI_DONE_O <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        if (req_bad) begin
                            state      <= DONE;
                            SPI_DONE_O <= 1'b1;
                            SPI_ERR_O  <= 1'b1;
                        end else begin
                            state      <= SETUP;
                            SPI_ERR_O  <= 1'b0;
                            SPI_BUSY_O <= 1'b1;
                            SPI_CSS    <= cs_pattern;
                            cpol_q     <= SPI_MODE_I[1];
                            cpha_q     <= SPI_MODE_I[0];
                            SPI_CLK    <= SPI_MODE_I[1];
                            len_q      <= SPI_LEN_I;
                            rx_sr      <= '0;
                            ph_cnt     <= '0;
                            div_cnt    <= '0;
                            edge_cnt   <= '0;
                            // CPHA=0 presents the first bit before any SCLK edge
                            if (!SPI_MODE_I[0]) begin
                                SPI_MOSI <= tx_aligned[DATA_W-1];
                                tx_sr    <= tx_aligned << 1;
                            end else begin
                                SPI_MOSI <= 1'b0;
                                tx_sr    <= tx_aligned;
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                SETUP: begin
                    if (ph_cnt == PH_W'(CS_SETUP - 1)) begin
                        state  <= SHIFT;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                SHIFT: begin
                    if (sclk_tick) begin
                        div_cnt <= '0;
                        SPI_CLK <= ~SPI_CLK;
                        if (sample_now) begin
                            rx_sr <= (rx_sr << 1) | DATA_W'(SPI_MISO);
                        end else begin
                            SPI_MOSI <= tx_sr[DATA_W-1];
                            tx_sr    <= tx_sr << 1;
                        end
                        if (edge_cnt == last_edge) begin
                            state    <= HOLD;
                            edge_cnt <= '0;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (ph_cnt == PH_W'(CS_HOLD - 1)) begin
                        state      <= DONE;
                        ph_cnt     <= '0;
                        SPI_CSS    <= '1;
                        SPI_DONE_O <= 1'b1;
                        SPI_BUSY_O <= 1'b0;
                        SPI_O      <= rx_sr;
                        SPI_MOSI   <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// ---------------------------------------------------------------------------
// tb_spi_master_param
//
// Self-checking bench for spi_master_param at default parameters. A slave
// model shifts a chosen word out on MISO and collects MOSI. Every launched
// request pushes its expected SPI_O/ERR onto a scoreboard queue, and the
// entry is popped when DONE is observed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_master_param;

    localparam time PERIOD = 10;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        star = 1'b0;
    logic [1:0]  sel  = 2'd0;
    logic [1:0]  mode = 2'd0;
    logic [5:0]  len  = 6'd0;
    logic [31:0] din  = 32'd0;
    logic        miso = 1'b0;

    logic [31:0] spi_o;
    logic        done;
    logic        busy;
    logic        err;
    logic        mosi;
    logic        sclk;
    logic [2:0]  css;

    spi_master_param dut (
        .BOARD_CLOCK (clk),
        .RST         (rst),
        .SPI_STAR_I  (star),
        .SPI_SEL_I   (sel),
        .SPI_MODE_I  (mode),
        .SPI_LEN_I   (len),
        .SPI_I       (din),
        .SPI_O       (spi_o),
        .SPI_DONE_O  (done),
        .SPI_BUSY_O  (busy),
        .SPI_ERR_O   (err),
        .SPI_MISO    (miso),
        .SPI_MOSI    (mosi),
        .SPI_CLK     (sclk),
        .SPI_CSS     (css)
    );

    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_good = 32'd0;
    int          errors = 0;
    int          checks = 0;

    // Slave model state
    logic [31:0] slv_word = 32'd0;
    logic [1:0]  slv_mode = 2'd0;
    int          slv_len  = 1;
    logic [31:0] slv_sr   = 32'd0;
    logic [31:0] slv_rx   = 32'd0;
    logic        slv_active = 1'b0;
    logic        slv_clk  = 1'b0;
    logic        slv_lead;
    int          rises = 0;
    int          toggles = 0;
    int          viol = 0;
    time         last_mosi_t = 0;
    time         last_samp_t = 0;

    // SPI slave: loads its word when a CS drops, drives MISO on its shift
    // edges and captures MOSI on its sample edges, using the mode the bench
    // asked for rather than anything read from the DUT.
    always @(css or sclk) begin
        if (css === 3'b111) begin
            slv_active = 1'b0;
        end else if (!slv_active) begin
            slv_active = 1'b1;
            slv_clk    = slv_mode[1];
            slv_rx     = 32'd0;
            slv_sr     = slv_word << (32 - slv_len);
            if (!slv_mode[0]) begin
                miso   = slv_sr[31];
                slv_sr = slv_sr << 1;
            end
        end else if (sclk !== slv_clk) begin
            slv_clk  = sclk;
            slv_lead = (sclk != slv_mode[1]);
            if (slv_lead ^ slv_mode[0]) begin
                slv_rx      = {slv_rx[30:0], mosi};
                last_samp_t = $time;
                if ($time - last_mosi_t <= PERIOD) viol++;
            end else begin
                miso   = slv_sr[31];
                slv_sr = slv_sr << 1;
            end
        end
    end

    // MOSI must stay quiet for a full cycle either side of a sample edge
    always @(mosi) begin
        last_mosi_t = $time;
        if (slv_active && ($time - last_samp_t <= PERIOD)) viol++;
    end

    always @(posedge sclk) rises++;
    always @(sclk) toggles++;

    // Drive a request and record what the DUT must report for it
    task automatic launch(input logic [1:0] s, input logic [1:0] m, input logic [5:0] l,
                          input logic [31:0] d, input logic [31:0] sw);
        exp_t        e;
        logic [31:0] mask;
        sel      = s;
        mode     = m;
        len      = l;
        din      = d;
        slv_word = sw;
        slv_mode = m;
        slv_len  = (l == 6'd0 || l > 6'd32) ? 1 : int'(l);
        if (s >= 2'd3 || l == 6'd0 || l > 6'd32) begin
            e.data = last_good;
            e.err  = 1'b1;
        end else begin
            mask      = (l == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << l) - 32'd1);
            e.data    = sw & mask;
            e.err     = 1'b0;
            last_good = e.data;
        end
        exp_q.push_back(e);
        star = 1'b1;
    endtask

    // Wait (bounded) for DONE; cycle 1 is the first cycle after the start
    task automatic wait_done(input int budget, output int cyc,
                             output logic [2:0] css1, output logic busy1);
        cyc   = -1;
        css1  = 3'bxxx;
        busy1 = 1'bx;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) begin
                star  = 1'b0;
                css1  = css;
                busy1 = busy;
            end
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int active;
        star = 1'b1;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (css !== 3'b111) begin errors++; $display("[TB] FAIL rst_css: got %b exp 111", css); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL rst_sclk: got %b exp 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("[TB] FAIL rst_mosi: got %b exp 0", mosi); end
        checks++; if (spi_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_data: got %h exp 0", spi_o); end
        checks++; if ({done, busy, err} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags: got %b exp 000", {done, busy, err}); end
        rst    = 1'b0;
        active = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || css !== 3'b111 || done !== 1'b0) active++;
        end
        checks++; if (active !== 0) begin errors++; $display("[TB] FAIL rst_held_start: got %0d active cycles exp 0", active); end
        star = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mode0_full();
        exp_t e;
        int   cyc, css_bad, busy_bad;
        @(negedge clk);
        rises = 0;
        launch(2'd2, 2'd0, 6'd32, 32'hCCCC_CCCE, 32'hFFFF_FFFF);
        cyc = -1; css_bad = 0; busy_bad = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 1) star = 1'b0;
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
            if (css !== 3'b011) css_bad++;
            if (busy !== 1'b1) busy_bad++;
        end
        checks++; if (cyc != 261) begin errors++; $display("[TB] FAIL m0_latency: got %0d exp 261", cyc); end
        checks++; if (css_bad != 0) begin errors++; $display("[TB] FAIL m0_css: got %0d bad cycles exp 0", css_bad); end
        checks++; if (busy_bad != 0) begin errors++; $display("[TB] FAIL m0_busy: got %0d bad cycles exp 0", busy_bad); end
        checks++; if (rises != 32) begin errors++; $display("[TB] FAIL m0_rises: got %0d exp 32", rises); end
        checks++; if (slv_rx !== 32'hCCCC_CCCE) begin errors++; $display("[TB] FAIL m0_mosi: got %h exp cccccccE", slv_rx); end
        checks++; if (css !== 3'b111 || busy !== 1'b0) begin errors++; $display("[TB] FAIL m0_done_state: got css=%b busy=%b exp 111/0", css, busy); end
        e = exp_q.pop_front();
        checks++; if (spi_o !== e.data) begin errors++; $display("[TB] FAIL m0_data: got %h exp %h", spi_o, e.data); end
        checks++; if (err !== e.err) begin errors++; $display("[TB] FAIL m0_err: got %b exp %b", err, e.err); end
    endtask

    task automatic test_start_held();
        exp_t e;
        int   dones, starts, first;
        logic busy_d;
        @(negedge clk);
        launch(2'd1, 2'd0, 6'd8, 32'h0000_0096, 32'h0000_003C);
        dones = 0; starts = 0; first = -1; busy_d = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 100) star = 1'b0;
            if (busy === 1'b1 && busy_d !== 1'b1) starts++;
            busy_d = busy;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) begin
                    first = i;
                    e = exp_q.pop_front();
                    checks++; if (spi_o !== e.data) begin errors++; $display("[TB] FAIL held_data: got %h exp %h", spi_o, e.data); end
                end
            end
        end
        checks++; if (dones != 1) begin errors++; $display("[TB] FAIL held_dones: got %0d exp 1", dones); end
        checks++; if (starts != 1) begin errors++; $display("[TB] FAIL held_starts: got %0d exp 1", starts); end
        checks++; if (first != 69) begin errors++; $display("[TB] FAIL held_latency: got %0d exp 69", first); end
    endtask

    task automatic test_modes();
        exp_t        e;
        int          cyc;
        logic [2:0]  css1;
        logic        busy1;
        logic [1:0]  mv;
        for (int m = 0; m < 4; m++) begin
            mv = 2'(m);
            @(negedge clk);
            viol = 0;
            launch(2'd1, mv, 6'd8, 32'h1234_56A5, 32'h1234_56A5);
            wait_done(200, cyc, css1, busy1);
            checks++; if (cyc != 69) begin errors++; $display("[TB] FAIL mode%0d_latency: got %0d exp 69", m, cyc); end
            checks++; if (css1 !== 3'b101) begin errors++; $display("[TB] FAIL mode%0d_css: got %b exp 101", m, css1); end
            e = exp_q.pop_front();
            checks++; if (spi_o !== e.data) begin errors++; $display("[TB] FAIL mode%0d_data: got %h exp %h", m, spi_o, e.data); end
            checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL mode%0d_err: got %b exp 0", m, err); end
            checks++; if (slv_rx !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL mode%0d_mosi: got %h exp 000000a5", m, slv_rx); end
            checks++; if (viol != 0) begin errors++; $display("[TB] FAIL mode%0d_mosi_timing: got %0d violations exp 0", m, viol); end
            repeat (3) @(negedge clk);
            checks++; if (sclk !== mv[1] || mosi !== 1'b0) begin errors++; $display("[TB] FAIL mode%0d_idle: got sclk=%b mosi=%b exp %b/0", m, sclk, mosi, mv[1]); end
        end
    endtask

    task automatic test_reject();
        exp_t        e;
        int          cyc, cs_low;
        logic [2:0]  css1;
        logic        busy1;
        logic [1:0]  bad_sel[3] = '{2'd3, 2'd0, 2'd1};
        logic [5:0]  bad_len[3] = '{6'd8, 6'd0, 6'd33};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            toggles = 0;
            launch(bad_sel[k], 2'd0, bad_len[k], 32'hFFFF_0000, 32'h5555_5555);
            wait_done(10, cyc, css1, busy1);
            checks++; if (cyc != 1) begin errors++; $display("[TB] FAIL rej%0d_latency: got %0d exp 1", k, cyc); end
            checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL rej%0d_err: got %b exp 1", k, err); end
            e = exp_q.pop_front();
            checks++; if (spi_o !== e.data) begin errors++; $display("[TB] FAIL rej%0d_data: got %h exp %h", k, spi_o, e.data); end
            cs_low = (css1 !== 3'b111 || busy1 !== 1'b0) ? 1 : 0;
            repeat (5) begin
                @(negedge clk);
                if (css !== 3'b111 || busy !== 1'b0) cs_low++;
            end
            checks++; if (cs_low != 0) begin errors++; $display("[TB] FAIL rej%0d_cs: got %0d active cycles exp 0", k, cs_low); end
            checks++; if (toggles != 0) begin errors++; $display("[TB] FAIL rej%0d_sclk: got %0d toggles exp 0", k, toggles); end
            checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL rej%0d_err_hold: got %b exp 1", k, err); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          cyc, extra;
        logic [2:0]  css1;
        logic        busy1;
        @(negedge clk);
        launch(2'd0, 2'd1, 6'd8, 32'h0000_005A, 32'h0000_00C3);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1 || i == 12) star = 1'b0;
            if (i == 10) star = 1'b1;
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
        checks++; if (cyc != 69) begin errors++; $display("[TB] FAIL b2b_a_latency: got %0d exp 69", cyc); end
        checks++; if (css !== 3'b111) begin errors++; $display("[TB] FAIL b2b_gap_css: got %b exp 111", css); end
        e = exp_q.pop_front();
        checks++; if (spi_o !== e.data) begin errors++; $display("[TB] FAIL b2b_a_data: got %h exp %h", spi_o, e.data); end
        launch(2'd1, 2'd0, 6'd16, 32'h0000_BEEF, 32'h0000_1234);
        wait_done(300, cyc, css1, busy1);
        checks++; if (css1 !== 3'b101 || busy1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_b_setup: got css=%b busy=%b exp 101/1", css1, busy1); end
        checks++; if (cyc != 133) begin errors++; $display("[TB] FAIL b2b_b_latency: got %0d exp 133", cyc); end
        e = exp_q.pop_front();
        checks++; if (spi_o !== e.data) begin errors++; $display("[TB] FAIL b2b_b_data: got %h exp %h", spi_o, e.data); end
        checks++; if (slv_rx !== 32'h0000_BEEF) begin errors++; $display("[TB] FAIL b2b_b_mosi: got %h exp 0000beef", slv_rx); end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL b2b_extra: got %0d active cycles exp 0", extra); end
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        int          cyc;
        logic [2:0]  css1;
        logic        busy1;
        @(negedge clk);
        launch(2'd0, 2'd2, 6'd32, 32'hDEAD_BEEF, 32'h0F0F_1234);
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 1) star = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (css !== 3'b111) begin errors++; $display("[TB] FAIL mid_rst_css: got %b exp 111", css); end
        checks++; if (sclk !== 1'b0 || mosi !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_bus: got sclk=%b mosi=%b exp 0/0", sclk, mosi); end
        checks++; if (spi_o !== 32'd0) begin errors++; $display("[TB] FAIL mid_rst_data: got %h exp 0", spi_o); end
        checks++; if ({done, busy, err} !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_flags: got %b exp 000", {done, busy, err}); end
        exp_q.delete();
        last_good = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        launch(2'd0, 2'd2, 6'd32, 32'hA1B2_C3D4, 32'h55AA_33CC);
        wait_done(400, cyc, css1, busy1);
        checks++; if (cyc != 261) begin errors++; $display("[TB] FAIL mid_latency: got %0d exp 261", cyc); end
        e = exp_q.pop_front();
        checks++; if (spi_o !== e.data) begin errors++; $display("[TB] FAIL mid_data: got %h exp %h", spi_o, e.data); end
        checks++; if (slv_rx !== 32'hA1B2_C3D4) begin errors++; $display("[TB] FAIL mid_mosi: got %h exp a1b2c3d4", slv_rx); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL mid_err: got %b exp 0", err); end
    endtask

    initial begin
        test_reset();
        test_mode0_full();
        test_start_held();
        test_modes();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
